// File: rtl/lcd_text_frame.sv
// lcd_text_frame: 2x16 character frame buffer streamed to an HD44780 driver as {rs, data} commands
module lcd_text_frame #(
  parameter int         REFRESH_PERIOD = 5400000,
  parameter logic [7:0] CLR_CHAR       = 8'h20,
  parameter logic [7:0] LINE1_CMD      = 8'h80,
  parameter logic [7:0] LINE2_CMD      = 8'hC0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic       init_done,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_data,
  input  logic       cmd_ready,
  output logic       busy,
  output logic       frame_done
);
  typedef enum logic [2:0] {IDLE, ADDR1, LINE1, ADDR2, LINE2} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_buf [32];
  logic        r_dirty, r_pend, r_valid, r_rs, r_busy, r_done;
  logic [31:0] r_cnt;
  logic [3:0]  r_col, w_col;
  logic [7:0]  r_data, w_data;
  logic        w_xfer, w_start, w_wrap, w_valid, w_rs, w_done;

  assign w_xfer     = r_valid & cmd_ready;
  assign w_start    = (r_state == IDLE) && init_done && (r_dirty || r_pend);
  assign w_wrap     = (REFRESH_PERIOD != 0) && (r_state == IDLE) && (r_cnt == 32'(REFRESH_PERIOD - 1));
  assign cmd_valid  = r_valid;
  assign cmd_rs     = r_rs;
  assign cmd_data   = r_data;
  assign busy       = r_busy;
  assign frame_done = r_done;

  // Frame sequencing: the next command byte is snapshotted from the buffer when it is first presented
  always_comb begin
    w_next  = r_state;
    w_col   = r_col;
    w_valid = r_valid;
    w_rs    = r_rs;
    w_data  = r_data;
    w_done  = 1'b0;
    case (r_state)
      IDLE:  if (w_start) begin
        w_next  = ADDR1;
        w_valid = 1'b1;
        w_rs    = 1'b0;
        w_data  = LINE1_CMD;
      end
      ADDR1: if (w_xfer) begin
        w_next = LINE1;
        w_col  = 4'd0;
        w_rs   = 1'b1;
        w_data = r_buf[0];
      end
      LINE1: if (w_xfer) begin
        if (r_col == 4'd15) begin
          w_next = ADDR2;
          w_rs   = 1'b0;
          w_data = LINE2_CMD;
        end else begin
          w_col  = r_col + 4'd1;
          w_data = r_buf[{1'b0, w_col}];
        end
      end
      ADDR2: if (w_xfer) begin
        w_next = LINE2;
        w_col  = 4'd0;
        w_rs   = 1'b1;
        w_data = r_buf[16];
      end
      LINE2: if (w_xfer) begin
        if (r_col == 4'd15) begin
          w_next  = IDLE;
          w_valid = 1'b0;
          w_rs    = 1'b0;
          w_data  = 8'h00;
          w_done  = 1'b1;
        end else begin
          w_col  = r_col + 4'd1;
          w_data = r_buf[{1'b1, w_col}];
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State, registered outputs, dirty/pending flags and the idle refresh counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_col   <= 4'd0;
      r_valid <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dirty <= 1'b1;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_col   <= w_col;
      r_valid <= w_valid;
      r_rs    <= w_rs;
      r_data  <= w_data;
      r_busy  <= w_next != IDLE;
      r_done  <= w_done;
      r_dirty <= wr_en | (r_dirty & ~w_start);
      r_pend  <= w_start ? 1'b0 : (w_wrap ? 1'b1 : r_pend);
      r_cnt   <= (r_state == IDLE && !w_start && !w_wrap) ? r_cnt + 32'd1 : 32'd0;
    end
  end

  // Character buffer; writes are accepted in every state
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= CLR_CHAR;
    end else if (wr_en) begin
      r_buf[wr_addr] <= wr_char;
    end
  end
endmodule

// File: tb/tb_lcd_text_frame.sv
// tb_lcd_text_frame: checks lcd_text_frame against a command-index reference model and fixed frame vectors
module tb_lcd_text_frame;
  logic       clk = 1'b0, reset = 1'b0, wr_en = 1'b0, init_done = 1'b0, cmd_ready = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic       v0, rs0, b0, f0, v1, rs1, b1, f1;
  logic [7:0] d0, d1;

  always #5 clk = ~clk;

  lcd_text_frame #(.REFRESH_PERIOD(0)) u0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .init_done(init_done), .cmd_valid(v0), .cmd_rs(rs0), .cmd_data(d0),
    .cmd_ready(cmd_ready), .busy(b0), .frame_done(f0));

  lcd_text_frame #(.REFRESH_PERIOD(100)) u1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .init_done(init_done), .cmd_valid(v1), .cmd_rs(rs1), .cmd_data(d1),
    .cmd_ready(cmd_ready), .busy(b1), .frame_done(f1));

  typedef struct {
    logic [31:0][7:0] cells;
    bit               dirty, pend, act, valid, rs, done;
    logic [7:0]       data;
    int               idx, cnt;
  } model_t;

  typedef struct {
    logic       wen;
    logic [4:0] addr;
    logic [7:0] ch;
    logic [8:0] exp;
  } vec_t;

  model_t     m0, m1;
  vec_t       tv [34];
  logic [8:0] q0 [$];
  int         tests = 0, fails = 0, n_fd0 = 0, n_fd1 = 0, m_fd1 = 0;
  bit         chk_on = 1'b0, rnd = 1'b0;

  // Command k of a frame: 0 = line-1 address, 1..16 = line 1, 17 = line-2 address, 18..33 = line 2
  function automatic logic [8:0] cmd_of(int k, logic [31:0][7:0] c);
    if (k == 0) return {1'b0, 8'h80};
    if (k <= 16) return {1'b1, c[5'(k - 1)]};
    if (k == 17) return {1'b0, 8'hC0};
    return {1'b1, c[5'(k - 2)]};
  endfunction

  function automatic model_t step(model_t m, int p, bit rst, bit wen, logic [4:0] wa,
                                  logic [7:0] wc, bit ini, bit rdy);
    model_t n = m;
    if (!rst) begin
      n.cells = {32{8'h20}};
      n.dirty = 1; n.pend = 0; n.act = 0; n.valid = 0; n.rs = 0; n.done = 0;
      n.data = 0; n.idx = 0; n.cnt = 0;
      return n;
    end
    n.done = 0;
    if (m.act) begin
      if (m.valid && rdy) begin
        if (m.idx == 33) begin
          n.act = 0; n.valid = 0; n.rs = 0; n.data = 0; n.done = 1;
        end else begin
          n.idx = m.idx + 1;
          {n.rs, n.data} = cmd_of(m.idx + 1, m.cells);
        end
      end
    end else if (ini && (m.dirty || m.pend)) begin
      n.act = 1; n.idx = 0; n.valid = 1; {n.rs, n.data} = cmd_of(0, m.cells);
      n.dirty = 0; n.pend = 0; n.cnt = 0;
    end else if (p != 0 && m.cnt == p - 1) begin
      n.pend = 1; n.cnt = 0;
    end else begin
      n.cnt = m.cnt + 1;
    end
    if (wen) begin
      n.cells[wa] = wc;
      n.dirty = 1;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic cmp(input string nm, input logic v, input logic rs, input logic [7:0] d,
                     input logic b, input logic f, input model_t m);
    tests++;
    if ({v, rs, d, b, f} !== {m.valid, m.rs, m.data, m.act, m.done}) begin
      fails++;
      $display("FAIL %s outputs {valid,rs,data,busy,done}: got %b %b %h %b %b, expected %b %b %h %b %b (t=%0t)",
               nm, v, rs, d, b, f, m.valid, m.rs, m.data, m.act, m.done, $time);
    end
  endtask

  task automatic wait_fd(input int n, input int lim);
    int b = n_fd0;
    int i = 0;
    while (n_fd0 < b + n && i < lim) begin
      @(negedge clk);
      i++;
    end
    chk("wait_frame_done", 32'(n_fd0 - b >= n), 1);
  endtask

  function automatic logic [8:0] q_at(int i);
    return (i < q0.size()) ? q0[i] : 9'bx;
  endfunction

  function automatic logic [8:0] blank(int i);
    return (i == 0) ? 9'h080 : (i == 17) ? 9'h0C0 : 9'h120;
  endfunction

  always @(posedge clk) begin
    if (reset && v0 && cmd_ready) q0.push_back({rs0, d0});
    if (f0) n_fd0++;
    if (f1) n_fd1++;
    if (m1.done) m_fd1++;
    m0 = step(m0, 0, reset, wr_en, wr_addr, wr_char, init_done, cmd_ready);
    m1 = step(m1, 100, reset, wr_en, wr_addr, wr_char, init_done, cmd_ready);
  end

  always @(negedge clk) begin
    if (rnd) cmd_ready = 1'($urandom_range(0, 1));
    if (chk_on) begin
      cmp("u0", v0, rs0, d0, b0, f0, m0);
      cmp("u1", v1, rs1, d1, b1, f1, m1);
    end
  end

  initial begin
    int bf, b1c, mb, bad, k;
    string s;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_valid", 32'(v0), 0);
    chk("rst_busy", 32'(b0), 0);
    chk("rst_rs_data", 32'({rs0, d0}), 0);
    chk("rst_done", 32'(f0), 0);

    init_done = 1'b1; cmd_ready = 1'b1; q0.delete(); bf = n_fd0; reset = 1'b1;
    wait_fd(1, 200);
    repeat (60) @(negedge clk);
    chk("t1_cmd_count", 32'(q0.size()), 34);
    chk("t1_frames", 32'(n_fd0 - bf), 1);
    for (int i = 0; i < 34; i++) chk($sformatf("t1_cmd%0d", i), 32'(q_at(i)), 32'(blank(i)));

    s = " Kim Woo Seong  ";
    for (int i = 0; i < 34; i++) begin
      tv[i].wen  = (i >= 1 && i <= 13);
      tv[i].addr = 5'(i);
      tv[i].ch   = (i < 16) ? s[i] : 8'h20;
      tv[i].exp  = (i == 0) ? 9'h080 : (i <= 16) ? {1'b1, s[i - 1]} : (i == 17) ? 9'h0C0 : 9'h120;
    end
    init_done = 1'b0;
    for (int i = 0; i < 34; i++) begin
      wr_en = tv[i].wen; wr_addr = tv[i].addr; wr_char = tv[i].ch;
      @(negedge clk);
    end
    wr_en = 1'b0; q0.delete(); bf = n_fd0; init_done = 1'b1;
    wait_fd(1, 200);
    repeat (60) @(negedge clk);
    chk("t2_cmd_count", 32'(q0.size()), 34);
    chk("t2_frames", 32'(n_fd0 - bf), 1);
    for (int i = 0; i < 34; i++) chk($sformatf("t2_cmd%0d", i), 32'(q_at(i)), 32'(tv[i].exp));

    q0.delete(); bf = n_fd0;
    wr_en = 1'b1; wr_addr = 5'd20; wr_char = 8'h51;
    @(negedge clk);
    wr_en = 1'b0; rnd = 1'b1;
    k = 0;
    while (!(m0.act && m0.idx == 6) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("t3_reach_col5", 32'(k < 1000), 1);
    rnd = 1'b0; cmd_ready = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd5; wr_char = 8'h58;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_stalled_byte", 32'({v0, rs0, d0}), 32'({2'b11, 8'h57}));
    rnd = 1'b1;
    wait_fd(2, 3000);
    rnd = 1'b0; cmd_ready = 1'b1;
    repeat (60) @(negedge clk);
    chk("t3_cmd_count", 32'(q0.size()), 68);
    chk("t3_frames", 32'(n_fd0 - bf), 2);
    chk("t3_f1_col5", 32'(q_at(6)), 32'({1'b1, 8'h57}));
    chk("t3_f2_col5", 32'(q_at(40)), 32'({1'b1, 8'h58}));
    chk("t3_f1_l2c4", 32'(q_at(22)), 32'({1'b1, 8'h51}));
    chk("t3_f2_l2c4", 32'(q_at(56)), 32'({1'b1, 8'h51}));

    reset = 1'b0; init_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (v0 !== 1'b0) bad++;
    end
    chk("t4_valid_while_uninit", 32'(bad), 0);
    init_done = 1'b1;
    for (k = 0; k < 3; k++) begin
      @(negedge clk);
      if (v0) break;
    end
    chk("t4_start_latency_ok", 32'(k <= 1), 1);
    wait_fd(1, 200);

    repeat (40) @(negedge clk);
    bf = n_fd0; b1c = n_fd1; mb = m_fd1;
    repeat (1000) @(negedge clk);
    chk("t5_refresh_frames", 32'(n_fd1 - b1c), 32'(m_fd1 - mb));
    chk("t5_refresh_active", 32'(n_fd1 - b1c >= 5), 1);
    chk("t5_no_refresh_p0", 32'(n_fd0 - bf), 0);

    wr_en = 1'b1; wr_addr = 5'd31; wr_char = 8'h5A;
    @(negedge clk);
    wr_en = 1'b0; k = 0;
    while (!(m0.act && m0.idx == 25) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reach_l2c7", 32'(k < 500), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_abort_valid", 32'(v0), 0);
    chk("t6_abort_busy", 32'(b0), 0);
    reset = 1'b1; q0.delete();
    wait_fd(1, 200);
    repeat (5) @(negedge clk);
    chk("t6_cmd_count", 32'(q0.size()), 34);
    for (int i = 0; i < 34; i++) chk($sformatf("t6_cmd%0d", i), 32'(q_at(i)), 32'(blank(i)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
